// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Brief    : PC / imem request generator with static branch prediction and
//            a small output FIFO toward decode.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
  parameter int                    word_width      = 32,
  parameter int                    FIFO_DEPTH      = 4,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter logic [word_width-1:0] RESET_PC        = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  output logic [word_width-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [word_width-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [word_width-1:0] redirect_pc,
  output logic [word_width:0]   inst,
  output logic [word_width-1:0] inst_addr,
  output logic                  inst_valid,
  input  logic                  inst_ready
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam int c_out_w = $clog2(MAX_OUTSTANDING + 1);
  localparam int c_sum_w = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1) + 1;

  localparam logic [c_out_w-1:0]    c_max_out   = c_out_w'(MAX_OUTSTANDING);
  localparam logic [c_cnt_w-1:0]    c_depth_cnt = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_sum_w-1:0]    c_depth_sum = c_sum_w'(FIFO_DEPTH);
  localparam logic [word_width-1:0] c_four      = word_width'(4);
  localparam logic [word_width-1:0] c_align     = ~word_width'(3);
  localparam logic [6:0]            c_op_branch = 7'b1100011;
  localparam logic [6:0]            c_op_jal    = 7'b1101111;

  logic [word_width-1:0] r_pc;
  logic [word_width-1:0] r_resp_pc;
  logic [c_out_w-1:0]    r_outstanding;
  logic [c_out_w-1:0]    r_drop_cnt;

  logic [word_width:0]   r_fifo_data [FIFO_DEPTH];
  logic [word_width-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;

  logic [6:0]            w_opcode;
  logic                  w_is_branch;
  logic                  w_is_jal;
  logic                  w_pred_taken;
  logic [word_width-1:0] w_b_imm;
  logic [word_width-1:0] w_j_imm;
  logic                  w_resp_accept;
  logic                  w_local_redirect;
  logic                  w_redirect;
  logic [word_width-1:0] w_local_target;
  logic [word_width-1:0] w_target;
  logic [c_sum_w-1:0]    w_credit_used;
  logic                  w_req_fire;
  logic                  w_push;
  logic                  w_pop;

  // Static prediction decode of the arriving response.
  assign w_opcode     = imem_resp_data[6:0];
  assign w_is_branch  = (w_opcode == c_op_branch);
  assign w_is_jal     = (w_opcode == c_op_jal);
  assign w_pred_taken = w_is_branch & imem_resp_data[31];

  assign w_b_imm = {{(word_width-12){imem_resp_data[31]}}, imem_resp_data[7],
                    imem_resp_data[30:25], imem_resp_data[11:8], 1'b0};
  assign w_j_imm = {{(word_width-20){imem_resp_data[31]}}, imem_resp_data[19:12],
                    imem_resp_data[20], imem_resp_data[30:21], 1'b0};

  // An external redirect suppresses the response in flight this cycle.
  assign w_resp_accept    = imem_resp_valid & (r_drop_cnt == '0) & ~redirect_valid;
  assign w_local_redirect = w_resp_accept & (w_pred_taken | w_is_jal);
  assign w_redirect       = redirect_valid | w_local_redirect;
  assign w_local_target   = r_resp_pc + (w_is_jal ? w_j_imm : w_b_imm);
  assign w_target         = (redirect_valid ? redirect_pc : w_local_target) & c_align;

  // FIFO slots already promised to live (non-stale) requests.
  assign w_credit_used = c_sum_w'(r_count) + c_sum_w'(r_outstanding) - c_sum_w'(r_drop_cnt);

  assign imem_req_valid = rst_n & (r_outstanding < c_max_out) &
                          (w_credit_used < c_depth_sum) & ~w_redirect;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign w_push = w_resp_accept;
  assign w_pop  = (r_count != '0) & inst_ready & ~redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (w_redirect) begin
        r_pc <= w_target;
      end else if (w_req_fire) begin
        r_pc <= r_pc + c_four;
      end

      if (w_redirect) begin
        r_resp_pc <= w_target;
      end else if (w_push) begin
        r_resp_pc <= r_resp_pc + c_four;
      end

      r_outstanding <= r_outstanding + c_out_w'(w_req_fire) - c_out_w'(imem_resp_valid);

      // Everything still in flight after this cycle belongs to the old path.
      if (w_redirect) begin
        r_drop_cnt <= r_outstanding - c_out_w'(imem_resp_valid);
      end else if (imem_resp_valid && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - c_out_w'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_addr[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= {w_pred_taken, imem_resp_data};
        r_fifo_addr[r_wr_ptr] <= r_resp_pc;
      end
      if (redirect_valid) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      end
    end
  end

  assign inst_valid = (r_count != '0);
  assign inst       = inst_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign inst_addr  = inst_valid ? r_fifo_addr[r_rd_ptr] : '0;

  a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
    r_outstanding <= c_max_out);
  a_fifo_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= c_depth_cnt);

endmodule
`default_nettype wire
